// File: rtl/rtttl_tone_gen_if.sv
// rtttl_tone_gen_if: note stream in, square-wave audio and sounding flag out
interface rtttl_tone_gen_if;
  logic       enable;
  logic [3:0] octave;
  logic [3:0] note;
  logic       trig;
  logic       audio_out;
  logic       sounding;
  modport master(output enable, octave, note, trig, input audio_out, sounding);
  modport slave(input enable, octave, note, trig, output audio_out, sounding);
endinterface

// File: rtl/rtttl_tone_gen.sv
// rtttl_tone_gen: square-wave synth for the RTTTL {octave, note} stream, silent gap on every new note
module rtttl_tone_gen #(
  parameter int GAP_CYCLES = 2000,
  parameter int HALF_W     = 16
) (
  input logic             clk,
  input logic             rstn,
  rtttl_tone_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GAP, TONE} state_t;
  localparam logic [10:0] TBL [12] = '{11'd1911, 11'd1804, 11'd1703, 11'd1607, 11'd1517, 11'd1432,
                                       11'd1351, 11'd1276, 11'd1204, 11'd1136, 11'd1073, 11'd1012};
  localparam logic [HALF_W-1:0] GAP_LAST = HALF_W'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [HALF_W-1:0] gap_cnt, gap_n, tone_cnt, tone_n, half_reg, half_n, half;
  logic [3:0] prev_oct, prev_note, osub, idx;
  logic [10:0] base;
  logic aud, aud_n, snd, en_q, evt, valid, gap_done, wrap;
  assign valid    = bus.note >= 4'd1 && bus.note <= 4'd12 && bus.octave >= 4'd4 && bus.octave <= 4'd7;
  assign idx      = bus.note - 4'd1;
  assign osub     = bus.octave - 4'd4;
  assign base     = valid ? TBL[idx] : '0;
  assign half     = HALF_W'(base >> osub[1:0]);
  assign evt      = bus.enable & (({bus.octave, bus.note} != {prev_oct, prev_note}) | bus.trig | ~en_q);
  assign gap_done = gap_cnt == GAP_LAST;
  assign wrap     = tone_cnt == half_reg - 1'b1;
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    if (!bus.enable)                      state_n = IDLE;
    else if (evt)                         state_n = !valid ? IDLE : GAP_CYCLES > 0 ? GAP : TONE;
    else if (state == GAP && gap_done)    state_n = TONE;
  end
  // Any event or disable restarts phase from zero; counting happens only without one
  always_comb begin
    gap_n  = '0;
    tone_n = '0;
    aud_n  = 1'b0;
    half_n = half_reg;
    if (evt) half_n = valid ? half : half_reg;
    else if (bus.enable) begin
      gap_n  = state == GAP && !gap_done ? gap_cnt + 1'b1 : '0;
      tone_n = state == TONE && !wrap ? tone_cnt + 1'b1 : '0;
      aud_n  = state == TONE && wrap ? ~aud : aud;
    end
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      gap_cnt   <= '0;
      tone_cnt  <= '0;
      half_reg  <= '0;
      aud       <= 1'b0;
      snd       <= 1'b0;
      en_q      <= 1'b0;
      prev_oct  <= '0;
      prev_note <= '0;
    end else begin
      gap_cnt   <= gap_n;
      tone_cnt  <= tone_n;
      half_reg  <= half_n;
      aud       <= aud_n;
      snd       <= state_n == TONE;
      en_q      <= bus.enable;
      prev_oct  <= bus.octave;
      prev_note <= bus.note;
    end
  always_comb begin
    bus.audio_out = aud;
    bus.sounding  = snd;
  end
endmodule

// File: tb/tb_rtttl_tone_gen.sv
// tb_rtttl_tone_gen: scoreboard of predicted audio edges for GAP_CYCLES=4 and GAP_CYCLES=0 instances
module tb_rtttl_tone_gen;
  typedef struct {int cyc; logic val;} tog_t;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  rtttl_tone_gen_if ia();
  rtttl_tone_gen_if ib();
  rtttl_tone_gen #(.GAP_CYCLES(4)) dut_a(.clk(clk), .rstn(rstn), .bus(ia.slave));
  rtttl_tone_gen #(.GAP_CYCLES(0)) dut_b(.clk(clk), .rstn(rstn), .bus(ib.slave));
  int cyc = 0, n_run = 0, n_fail = 0, tstart = 0, half = 0, pushed = 0, gap = 4;
  int tbl [13] = '{0, 1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012};
  logic sel = 1'b0, mlev = 1'b0, last = 1'b0, active = 1'b0;
  logic aud_o, snd_o;
  tog_t q [$];
  assign aud_o = sel ? ib.audio_out : ia.audio_out;
  assign snd_o = sel ? ib.sounding : ia.sounding;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, int got, int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // Every audio edge must match the head of the queue in cycle and level
  always @(negedge clk) begin
    tog_t e;
    if (aud_o !== last) begin
      if (q.size() == 0) chk("spurious_edge", int'(aud_o), int'(last));
      else begin
        e = q.pop_front();
        chk("edge_cycle", cyc, e.cyc);
        chk("edge_level", int'(aud_o), int'(e.val));
        mlev = e.val;
      end
      last = aud_o;
    end else if (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missed_edge", cyc, e.cyc);
      mlev = e.val;
    end
  end
  task automatic setin(logic en, logic [3:0] oc, logic [3:0] nt, logic tr);
    ia.enable = en; ia.octave = oc; ia.note = nt; ia.trig = tr;
    ib.enable = en; ib.octave = oc; ib.note = nt; ib.trig = tr;
  endtask
  task automatic retire();
    q.delete();
    if (mlev) q.push_back('{cyc + 1, 1'b0});
    active = 1'b0;
  endtask
  task automatic start(logic [3:0] oc, logic [3:0] nt);
    if (nt >= 1 && nt <= 12 && oc >= 4 && oc <= 7) begin
      active = 1'b1;
      half   = tbl[nt] >> (oc - 4);
      tstart = cyc + 1 + gap;
      pushed = cyc;
    end
  endtask
  task automatic apply(logic en, logic [3:0] oc, logic [3:0] nt, logic tr);
    setin(en, oc, nt, tr);
    retire();
    if (en) start(oc, nt);
  endtask
  task automatic run(int n);
    int h = cyc + n;
    if (active)
      for (int k = 0; tstart + half * (k + 1) <= h; k++)
        if (tstart + half * (k + 1) > pushed) q.push_back('{tstart + half * (k + 1), k % 2 == 0});
    pushed = h;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  initial begin
    setin(1'b0, 4'd0, 4'd0, 1'b0);
    rstn = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    chk("reset_audio", int'(aud_o), 0);
    chk("reset_sounding", int'(snd_o), 0);
    rstn = 1'b1;
    run(10);
    chk("idle_sounding", int'(snd_o), 0);
    apply(1'b1, 4'd4, 4'd10, 1'b0);
    run(4);
    chk("gap_sounding", int'(snd_o), 0);
    run(1);
    chk("tone_sounding", int'(snd_o), 1);
    run(5000);
    apply(1'b1, 4'd5, 4'd5, 1'b0);
    run(3000);
    apply(1'b1, 4'd5, 4'd5, 1'b1);
    run(1);
    setin(1'b1, 4'd5, 4'd5, 1'b0);
    run(2999);
    run(3000);
    apply(1'b1, 4'd5, 4'd0, 1'b0);
    run(1);
    chk("rest_sounding", int'(snd_o), 0);
    run(100);
    apply(1'b1, 4'd7, 4'd12, 1'b0);
    run(1000);
    apply(1'b1, 4'd3, 4'd12, 1'b0);
    run(1);
    chk("oct3_sounding", int'(snd_o), 0);
    run(50);
    apply(1'b1, 4'd7, 4'd12, 1'b0);
    run(600);
    apply(1'b0, 4'd7, 4'd12, 1'b0);
    run(1);
    chk("disable_sounding", int'(snd_o), 0);
    run(50);
    sel = 1'b1;
    gap = 0;
    apply(1'b1, 4'd6, 4'd1, 1'b0);
    run(1);
    chk("nogap_sounding", int'(snd_o), 1);
    run(2000);
    rstn = 1'b0;
    retire();
    run(1);
    chk("midreset_sounding", int'(snd_o), 0);
    chk("midreset_audio", int'(aud_o), 0);
    rstn = 1'b1;
    start(4'd6, 4'd1);
    run(1500);
    apply(1'b0, 4'd6, 4'd1, 1'b0);
    run(20);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rtttl_tone_gen.md
Name: rtttl_tone_gen

Overview:
Consumes the {octave, note} stream produced by the RTTTL melody sequencer and synthesizes a square-wave audio output at the matching pitch. The clock is 1 MHz. Pitch comes from a 12-entry half-period table for octave 4, right-shifted for higher octaves. A short silent gap is inserted on every note change or retrigger so that repeated notes stay audibly articulated.

Parameters:
GAP_CYCLES, 2000, silent cycles inserted before each new tone (0 = no gap); max 65535
HALF_W, 16, width of the half-period and gap counters

Ports:
clk  input  1  system clock, 1 MHz
rstn  input  1  synchronous active-low reset
enable  input  1  1 = generate audio; 0 = force silence
octave  input  4  octave number; valid range 4..7
note  input  4  1=C,2=C#,3=D,4=D#,5=E,6=F,7=F#,8=G,9=G#,10=A,11=A#,12=B; 0 and 13..15 = rest
trig  input  1  one-cycle pulse that re-articulates the current note (tie 0 if unused)
audio_out  output  1  square-wave audio
sounding  output  1  high while in TONE state

Behaviour:
- Reset (rstn=0 at a posedge): state=IDLE, audio_out=0, sounding=0, all counters=0, prev_{octave,note}=0. Reset mid-tone takes effect on the next edge and silences immediately.
- prev_{octave,note} registers capture the inputs every cycle.
- event = enable & (({octave,note} != prev) | trig | enable rose this cycle). An enable rise is detected from a registered copy of enable.
- valid = (1<=note<=12) & (4<=octave<=7).
- Octave-4 half-period table, in cycles: C 1911, C# 1804, D 1703, D# 1607, E 1517, F 1432, F# 1351, G 1276, G# 1204, A 1136, A# 1073, B 1012.
- half = table[note] >> (octave-4), truncating. It is latched into half_reg on the event edge.
- States are IDLE, GAP and TONE. Priority order per edge: reset > !enable > event > normal count.
- !enable: go to IDLE, audio_out=0, counters cleared.
- event with !valid: go to IDLE, audio_out=0.
- event with valid and GAP_CYCLES>0: go to GAP, gap_cnt=0, tone_cnt=0, audio_out=0, half_reg latched.
- event with valid and GAP_CYCLES=0: go directly to TONE, tone_cnt=0, audio_out=0.
- An event in any state, including mid-GAP or mid-TONE, restarts from these rules. Phase is reset and there is no glitch-free handover.
- GAP: gap_cnt increments each cycle. When gap_cnt==GAP_CYCLES-1, go to TONE and set tone_cnt=0. audio_out stays 0.
- TONE: tone_cnt increments each cycle. When tone_cnt==half_reg-1, audio_out toggles and tone_cnt=0. The tone continues indefinitely until the next event or !enable.
- IDLE: no counting. Leaves only on event with valid.
- sounding is registered and equals (state==TONE).
- Timing: for an event sampled at edge E, audio_out first rises at edge E+GAP_CYCLES+half_reg. The output period is 2*half_reg cycles at 50% duty.
- Counters are HALF_W bits and never wrap in legal use: max half = 1911, max GAP = 65535 at HALF_W=16.

Test Plan:
- Reset held 5 cycles, then released with enable=0 -> audio_out=0 and sounding=0 throughout.
- GAP_CYCLES=4, enable=1, octave=4, note=10 (A4) -> audio_out low for 4+1136 cycles after the event edge, then toggles every 1136 cycles (period 2272); sounding rises 4 cycles after the event.
- Input changes to octave=5, note=5 mid-tone -> audio_out=0 on the next edge, 4-cycle gap, then half=758 (1517>>1).
- trig pulse with unchanged octave=5, note=5 -> gap re-inserted and phase restarted; the same with trig=0 and unchanged inputs causes no interruption.
- note=0 or octave=3 while sounding -> IDLE, audio_out=0, sounding=0 on the next edge; returning to octave=7, note=12 -> half=126 (1012>>3).
- GAP_CYCLES=0 and note=1, octave=6 -> first rise exactly 477 cycles after the event (1911>>2). Deasserting enable or rstn mid-tone -> audio_out=0 on the following edge.
